// File: rtl/cnt163_seq_ctrl.sv
// Control sequencer for a cascade of Vr74x163 4-bit counters.
// The cascade and this block form a programmable one-shot / periodic interval timer.
// The counter is loaded with 2^WIDTH - PERIOD, so it reaches terminal count after
// exactly PERIOD enabled clocks.
module cnt163_seq_ctrl #(
  parameter int WIDTH = 8  // multiple of 4, one counter stage per nibble
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             START,
  input  logic             STOP,
  input  logic             HOLD,
  input  logic             MODE,
  input  logic [WIDTH-1:0] PERIOD,
  input  logic             CNT_RCO,
  output logic             CNT_CLR_L,
  output logic             CNT_LD_L,
  output logic             CNT_ENP,
  output logic             CNT_ENT,
  output logic [WIDTH-1:0] CNT_D,
  output logic             BUSY,
  output logic             TICK,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             term;

  // Terminal event: cascade at all-ones and actually counting this cycle.
  // HOLD masks it so a held RCO fires on the first cycle after HOLD drops.
  assign term = CNT_RCO & ~HOLD & (state_q == S_RUN);

  // Next-state, captured configuration and pulse generation.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    load_d  = load_q;
    tick_d  = term & ~STOP;
    done_d  = term & ~mode_q & ~STOP;
    case (state_q)
      S_IDLE: begin
        // PERIOD of 0 has no meaningful interval, so START is ignored.
        if (START && (PERIOD != '0)) begin
          state_d = S_LOAD;
          mode_d  = MODE;
          load_d  = -PERIOD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        // STOP wins over a coincident terminal event.
        if (STOP)                state_d = S_IDLE;
        else if (term && !mode_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and configuration registers.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      load_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      load_q  <= load_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  // Counter controls are combinational so the cascade acts on the same edge
  // as the state change. In RUN, LD_L reloads on terminal count in periodic
  // mode; load has priority over count inside the counter stages.
  always_comb begin
    CNT_CLR_L = 1'b0;
    CNT_LD_L  = 1'b1;
    CNT_ENP   = 1'b0;
    CNT_ENT   = 1'b0;
    case (state_q)
      S_IDLE: begin
        CNT_CLR_L = 1'b0;
      end
      S_LOAD: begin
        CNT_CLR_L = 1'b1;
        CNT_LD_L  = 1'b0;
      end
      S_RUN: begin
        CNT_ENT   = 1'b1;
        CNT_ENP   = ~HOLD;
        CNT_CLR_L = ~STOP;
        CNT_LD_L  = ~(term & mode_q & ~STOP);
      end
      default: begin
        CNT_CLR_L = 1'b0;
      end
    endcase
  end

  assign CNT_D = load_q;
  assign BUSY  = (state_q != S_IDLE);
  assign TICK  = tick_q;
  assign DONE  = done_q;

endmodule
